// File: rtl/tm_reorder_buffer.sv
// tm_reorder_buffer
// Receive-side reorder buffer for a master talking to several slaves whose
// responses return over different VCs and thus out of order. A sequential
// tag is handed out per request; each tag owns one storage slot. Responses
// may arrive in any order and are released to the module in issue order.
//
// Ports:
//   clk, rst          clock; asynchronous active-low reset
//   issue_valid_in    module wants to send a request
//   issue_ready_out   a tag is free (credit available)
//   issue_tag_out     tag to attach to the outgoing request (tail)
//   rx_valid_in/rx_ready_out/rx_tag_in/rx_data_in
//                     tagged response from the dpkt (never backpressured)
//   rx_valid_out/rx_ready_in/rx_data_out
//                     in-order response stream to the module
//   outstanding_out   tags issued and not yet popped
//   err_out           sticky: a response arrived with an illegal tag
module tm_reorder_buffer #(
    parameter int WIDTH_DATA = 36,
    parameter int WIDTH_TAG  = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  issue_valid_in,
    output logic                  issue_ready_out,
    output logic [WIDTH_TAG-1:0]  issue_tag_out,
    input  logic                  rx_valid_in,
    output logic                  rx_ready_out,
    input  logic [WIDTH_TAG-1:0]  rx_tag_in,
    input  logic [WIDTH_DATA-1:0] rx_data_in,
    output logic                  rx_valid_out,
    input  logic                  rx_ready_in,
    output logic [WIDTH_DATA-1:0] rx_data_out,
    output logic [WIDTH_TAG:0]    outstanding_out,
    output logic                  err_out
);
    localparam int DEPTH = 1 << WIDTH_TAG;

    logic [WIDTH_TAG-1:0]  head;
    logic [WIDTH_TAG-1:0]  tail;
    logic [WIDTH_TAG:0]    count;
    logic [DEPTH-1:0]      filled;
    logic [WIDTH_DATA-1:0] mem [DEPTH];
    logic                  err;

    logic                  issue_fire;
    logic                  pop;
    logic [WIDTH_TAG-1:0]  rx_off;
    logic                  rx_alloc;
    logic                  rx_ok;
    logic [DEPTH-1:0]      set_mask;
    logic [DEPTH-1:0]      clr_mask;

    // count never exceeds DEPTH, so its MSB alone means "full".
    // Depends on registers only: a same-cycle pop does not free a credit.
    assign issue_ready_out = ~count[WIDTH_TAG];
    assign issue_tag_out   = tail;
    assign rx_ready_out    = 1'b1;
    assign rx_valid_out    = filled[head];
    assign rx_data_out     = mem[head];
    assign outstanding_out = count;
    assign err_out         = err;

    assign issue_fire = issue_valid_in & issue_ready_out;
    assign pop        = rx_valid_out & rx_ready_in;

    // A tag is allocated when its distance from head is below count; this
    // uses pre-issue state, so a tag issued this same cycle is not yet legal.
    assign rx_off   = rx_tag_in - head;
    assign rx_alloc = ({1'b0, rx_off} < count);
    assign rx_ok    = rx_valid_in & rx_alloc & ~filled[rx_tag_in];

    // Set and clear never hit the same slot: a pop needs filled[head] while
    // a write needs ~filled[tag].
    always_comb begin
        set_mask = '0;
        clr_mask = '0;
        if (rx_ok) set_mask[rx_tag_in] = 1'b1;
        if (pop)   clr_mask[head]      = 1'b1;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            head   <= '0;
            tail   <= '0;
            count  <= '0;
            filled <= '0;
            err    <= 1'b0;
        end else begin
            if (issue_fire) tail <= tail + 1'b1;
            if (pop)        head <= head + 1'b1;
            filled <= (filled & ~clr_mask) | set_mask;
            if (rx_valid_in && !rx_ok) err <= 1'b1;
            case ({issue_fire, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Payload storage is not reset; validity is tracked by filled[].
    always_ff @(posedge clk) begin
        if (rx_ok) mem[rx_tag_in] <= rx_data_in;
    end
endmodule

// File: tb/tb_tm_reorder_buffer.sv
module tb_tm_reorder_buffer;
    logic        clk;
    logic        rst;
    logic        issue_valid_in;
    logic        issue_ready_out;
    logic [2:0]  issue_tag_out;
    logic        rx_valid_in;
    logic        rx_ready_out;
    logic [2:0]  rx_tag_in;
    logic [35:0] rx_data_in;
    logic        rx_valid_out;
    logic        rx_ready_in;
    logic [35:0] rx_data_out;
    logic [3:0]  outstanding_out;
    logic        err_out;

    int checks = 0;
    int errors = 0;

    tm_reorder_buffer #(.WIDTH_DATA(36), .WIDTH_TAG(3)) dut (
        .clk(clk), .rst(rst),
        .issue_valid_in(issue_valid_in), .issue_ready_out(issue_ready_out),
        .issue_tag_out(issue_tag_out),
        .rx_valid_in(rx_valid_in), .rx_ready_out(rx_ready_out),
        .rx_tag_in(rx_tag_in), .rx_data_in(rx_data_in),
        .rx_valid_out(rx_valid_out), .rx_ready_in(rx_ready_in),
        .rx_data_out(rx_data_out), .outstanding_out(outstanding_out),
        .err_out(err_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One vector = inputs held across one rising edge, plus the outputs
    // expected just before that edge (i.e. the state left by the previous one).
    typedef struct {
        string       name;
        bit          rst_first;
        bit          iv;
        bit          rv;
        logic [2:0]  tag;
        logic [35:0] d;
        bit          rr;
        bit          e_ir;
        logic [2:0]  e_tag;
        bit          e_vo;
        logic [35:0] e_d;
        logic [3:0]  e_out;
        bit          e_err;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input string name, input bit rf, input bit iv, input bit rv,
                       input logic [2:0] tag, input logic [35:0] d, input bit rr,
                       input bit e_ir, input logic [2:0] e_tag, input bit e_vo,
                       input logic [35:0] e_d, input logic [3:0] e_out, input bit e_err);
        vec_t v;
        v.name = name; v.rst_first = rf; v.iv = iv; v.rv = rv; v.tag = tag;
        v.d = d; v.rr = rr; v.e_ir = e_ir; v.e_tag = e_tag; v.e_vo = e_vo;
        v.e_d = e_d; v.e_out = e_out; v.e_err = e_err;
        vecs.push_back(v);
    endtask

    task automatic chk(input string name, input int idx, input logic [35:0] act,
                       input logic [35:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s (vec %0d): got %0h expected %0h", name, idx, act, exp);
        end
    endtask

    task automatic idle_inputs();
        issue_valid_in = 1'b0;
        rx_valid_in    = 1'b0;
        rx_tag_in      = '0;
        rx_data_in     = '0;
        rx_ready_in    = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        idle_inputs();
        rst = 1'b0;
        #2;
        rst = 1'b1;
    endtask

    task automatic check_outputs(input string n, input int i, input bit ir,
                                 input logic [2:0] tg, input bit vo, input logic [35:0] d,
                                 input logic [3:0] o, input bit e);
        chk({n, ".issue_ready"}, i, 36'(issue_ready_out), 36'(ir));
        chk({n, ".issue_tag"},   i, 36'(issue_tag_out),   36'(tg));
        chk({n, ".rx_valid"},    i, 36'(rx_valid_out),    36'(vo));
        chk({n, ".outstanding"}, i, 36'(outstanding_out), 36'(o));
        chk({n, ".err"},         i, 36'(err_out),         36'(e));
        chk({n, ".rx_ready"},    i, 36'(rx_ready_out),    36'd1);
        if (vo) chk({n, ".rx_data"}, i, rx_data_out, d);
    endtask

    initial begin
        rst = 1'b1;
        idle_inputs();
        //   name     rf iv rv tag data   rr  ir tag vo data   out err
        // In-order
        add("inord", 1, 1, 0, 0, 0,     0,  1, 0, 0, 0,     0, 0);
        add("inord", 0, 1, 0, 0, 0,     0,  1, 1, 0, 0,     1, 0);
        add("inord", 0, 1, 0, 0, 0,     0,  1, 2, 0, 0,     2, 0);
        add("inord", 0, 0, 1, 0, 'hA,   1,  1, 3, 0, 0,     3, 0);
        add("inord", 0, 0, 1, 1, 'hB,   1,  1, 3, 1, 'hA,   3, 0);
        add("inord", 0, 0, 1, 2, 'hC,   1,  1, 3, 1, 'hB,   2, 0);
        add("inord", 0, 0, 0, 0, 0,     1,  1, 3, 1, 'hC,   1, 0);
        add("inord", 0, 0, 0, 0, 0,     1,  1, 3, 0, 0,     0, 0);
        // Reorder: responses 3,1,2,0
        add("reord", 1, 1, 0, 0, 0,     0,  1, 0, 0, 0,     0, 0);
        add("reord", 0, 1, 0, 0, 0,     0,  1, 1, 0, 0,     1, 0);
        add("reord", 0, 1, 0, 0, 0,     0,  1, 2, 0, 0,     2, 0);
        add("reord", 0, 1, 0, 0, 0,     0,  1, 3, 0, 0,     3, 0);
        add("reord", 0, 0, 1, 3, 'h3,   1,  1, 4, 0, 0,     4, 0);
        add("reord", 0, 0, 1, 1, 'h1,   1,  1, 4, 0, 0,     4, 0);
        add("reord", 0, 0, 1, 2, 'h2,   1,  1, 4, 0, 0,     4, 0);
        add("reord", 0, 0, 1, 0, 'h0,   1,  1, 4, 0, 0,     4, 0);
        add("reord", 0, 0, 0, 0, 0,     1,  1, 4, 1, 'h0,   4, 0);
        add("reord", 0, 0, 0, 0, 0,     1,  1, 4, 1, 'h1,   3, 0);
        add("reord", 0, 0, 0, 0, 0,     1,  1, 4, 1, 'h2,   2, 0);
        add("reord", 0, 0, 0, 0, 0,     1,  1, 4, 1, 'h3,   1, 0);
        add("reord", 0, 0, 0, 0, 0,     1,  1, 4, 0, 0,     0, 0);
        // Full / credit / tail wrap
        for (int i = 0; i < 8; i++)
            add("full", (i == 0), 1, 0, 0, 0, 0, 1, 3'(i), 0, 0, 4'(i), 0);
        add("full",  0, 1, 0, 0, 0,     0,  0, 0, 0, 0,     8, 0);
        add("full",  0, 1, 1, 0, 'h77,  1,  0, 0, 0, 0,     8, 0);
        add("full",  0, 1, 0, 0, 0,     1,  0, 0, 1, 'h77,  8, 0);
        add("full",  0, 1, 0, 0, 0,     0,  1, 0, 0, 0,     7, 0);
        add("full",  0, 0, 0, 0, 0,     0,  0, 1, 0, 0,     8, 0);
        // Backpressure, then pop + issue in the same cycle
        add("bp",    1, 1, 0, 0, 0,     0,  1, 0, 0, 0,     0, 0);
        add("bp",    0, 0, 1, 0, 'h55,  0,  1, 1, 0, 0,     1, 0);
        for (int i = 0; i < 5; i++)
            add("bp",  0, 0, 0, 0, 0,   0,  1, 1, 1, 'h55,  1, 0);
        add("bp",    0, 1, 0, 0, 0,     1,  1, 1, 1, 'h55,  1, 0);
        add("bp",    0, 0, 0, 0, 0,     1,  1, 2, 0, 0,     1, 0);
        // Errors: response while empty
        add("err",   1, 0, 1, 2, 'h99,  1,  1, 0, 0, 0,     0, 0);
        add("err",   0, 0, 0, 0, 0,     1,  1, 0, 0, 0,     0, 1);
        // Errors: duplicate response keeps original data
        add("dup",   1, 1, 0, 0, 0,     0,  1, 0, 0, 0,     0, 0);
        add("dup",   0, 1, 0, 0, 0,     0,  1, 1, 0, 0,     1, 0);
        add("dup",   0, 0, 1, 1, 'h11,  0,  1, 2, 0, 0,     2, 0);
        add("dup",   0, 0, 1, 1, 'h22,  0,  1, 2, 0, 0,     2, 0);
        add("dup",   0, 0, 1, 0, 'h10,  0,  1, 2, 0, 0,     2, 1);
        add("dup",   0, 0, 0, 0, 0,     1,  1, 2, 1, 'h10,  2, 1);
        add("dup",   0, 0, 0, 0, 0,     1,  1, 2, 1, 'h11,  1, 1);
        add("dup",   0, 0, 0, 0, 0,     1,  1, 2, 0, 0,     0, 1);
        // Response to the tag being issued in the same cycle is illegal
        add("sameiss", 1, 1, 1, 0, 'h5, 1,  1, 0, 0, 0,     0, 0);
        add("sameiss", 0, 0, 0, 0, 0,   1,  1, 1, 0, 0,     1, 1);

        foreach (vecs[i]) begin
            if (vecs[i].rst_first) do_reset();
            @(negedge clk);
            issue_valid_in = vecs[i].iv;
            rx_valid_in    = vecs[i].rv;
            rx_tag_in      = vecs[i].tag;
            rx_data_in     = vecs[i].d;
            rx_ready_in    = vecs[i].rr;
            #1;
            check_outputs(vecs[i].name, i, vecs[i].e_ir, vecs[i].e_tag, vecs[i].e_vo,
                          vecs[i].e_d, vecs[i].e_out, vecs[i].e_err);
        end

        // Async reset mid-cycle with 3 outstanding, one filled, err set
        do_reset();
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            idle_inputs();
            issue_valid_in = 1'b1;
        end
        @(negedge clk);
        idle_inputs();
        rx_valid_in = 1'b1; rx_tag_in = 3'd0; rx_data_in = 36'h123;
        @(negedge clk);
        idle_inputs();
        rx_valid_in = 1'b1; rx_tag_in = 3'd5; rx_data_in = 36'h0;
        @(negedge clk);
        idle_inputs();
        #1;
        check_outputs("pre_arst", 900, 1'b1, 3'd3, 1'b1, 36'h123, 4'd3, 1'b1);
        #1;
        rst = 1'b0;
        #1;
        check_outputs("arst", 901, 1'b1, 3'd0, 1'b0, 36'h0, 4'd0, 1'b0);
        #1;
        rst = 1'b1;
        // Stale tag after reset
        @(negedge clk);
        rx_valid_in = 1'b1; rx_tag_in = 3'd1; rx_data_in = 36'h7;
        @(negedge clk);
        idle_inputs();
        #1;
        check_outputs("stale", 902, 1'b1, 3'd0, 1'b0, 36'h0, 4'd0, 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/tm_reorder_buffer.md
Name: tm_reorder_buffer

Overview:
- Sits on the receive path of a master that sends to multiple slaves over different return VCs; responses come back from the dpkts out of order.
- Hands out sequential tags at send time and keeps one storage slot per outstanding tag.
- Accepts tagged responses in any order and releases them to the module strictly in issue order.
- Issue-side backpressure acts as the master's credit limit.

Parameters:
WIDTH_DATA, 36, response payload width
WIDTH_TAG, 3, tag width; DEPTH = 2**WIDTH_TAG slots (8); also the maximum outstanding requests

Ports:
clk  input  1  clock
rst  input  1  reset, asynchronous, active-low
issue_valid_in  input  1  module wants to send a request
issue_ready_out  output  1  a tag is available; the request may go to the pkt
issue_tag_out  output  WIDTH_TAG  tag to attach to the request (current tail pointer)
rx_valid_in  input  1  response valid from dpkt
rx_ready_out  output  1  response accepted
rx_tag_in  input  WIDTH_TAG  tag carried by the response
rx_data_in  input  WIDTH_DATA  response payload
rx_valid_out  output  1  in-order response valid to module
rx_ready_in  input  1  module accepts response
rx_data_out  output  WIDTH_DATA  in-order response payload
outstanding_out  output  WIDTH_TAG+1  tags issued and not yet popped
err_out  output  1  sticky: illegal response tag seen

Behaviour:
- Reset (rst low, async):
  - head = 0, tail = 0, count = 0, all filled[] = 0, err_out = 0.
  - Outputs: issue_ready_out = 1, issue_tag_out = 0, rx_valid_out = 0, rx_ready_out = 1, outstanding_out = 0.
  - rx_data_out is don't-care. Storage contents are not reset.
- State per slot i: alloc[i] (i lies in [head, tail) modulo DEPTH, derived from the pointers and count) and filled[i] (register).
- Issue:
  - issue_ready_out = (count < DEPTH), taken from registers only; there is no combinational path from rx_ready_in or rx_valid_in.
  - issue_tag_out = tail.
  - On issue_valid_in & issue_ready_out: tail <= tail+1, wrapping modulo DEPTH.
- Receive:
  - rx_ready_out is held at 1; storage is pre-allocated, so responses are never backpressured.
  - On rx_valid_in with alloc[rx_tag_in] & ~filled[rx_tag_in]: mem[tag] <= rx_data_in, filled[tag] <= 1.
  - Otherwise (tag not outstanding, or slot already filled): the response is dropped and err_out <= 1 until reset.
- Release:
  - rx_valid_out = filled[head]; rx_data_out = mem[head] (combinational read of registered state).
  - On rx_valid_out & rx_ready_in: filled[head] <= 0, head <= head+1 (wrap).
  - rx_data_out holds stable while rx_valid_out=1 and rx_ready_in=0.
- Latency: a response written at edge N can appear on rx_valid_out after edge N (1 cycle) if its tag is head.
- count:
  - +1 on issue only, −1 on pop only, unchanged when both occur in the same cycle.
  - outstanding_out = count.
- Boundaries:
  - Full (count = DEPTH): issue_ready_out = 0 even if a pop happens the same cycle; it rises the cycle after the pop.
  - Empty (count = 0): rx_valid_out = 0; any response sets err_out.
  - Wrap: tail 7 → 0; tag 0 can be reissued only after the previous tag 0 has been popped (guaranteed by the count check).
  - Same-cycle response to head plus pop: impossible, since a pop requires filled[head] while the write requires ~filled. A response with tag = head while head is empty is written; it is not bypassed.
  - Same-cycle issue and response: the response is checked against the alloc state before the issue (the newly issued tag is not yet valid).
  - Reset mid-operation: all outstanding responses are discarded; any later response with a stale tag sets err_out.

Test Plan:
- In-order: issue tags 0,1,2; respond tags 0,1,2 with data 0xA,0xB,0xC; rx_ready_in=1 → rx_data_out 0xA,0xB,0xC on consecutive cycles, each 1 cycle after its write; outstanding_out ends at 0.
- Reorder: issue 0..3; respond tags 3,1,2,0 with data 0x3,0x1,0x2,0x0 → rx_valid_out stays 0 until tag 0 is written, then 0x0,0x1,0x2,0x3 on 4 consecutive cycles.
- Full/credit: 8 issues with no responses → issue_ready_out=0, outstanding_out=8; respond tag 0 and pop → issue_ready_out=1 the cycle after the pop; the next issue_tag_out=0 (wrap).
- Backpressure: tag 0 filled with 0x55, rx_ready_in=0 for 5 cycles → rx_valid_out=1 and rx_data_out=0x55 stable; head advances only when rx_ready_in=1.
- Errors: with count=0, a response with tag 2 → err_out=1, nothing is stored; with tag 1 already filled, a second response to tag 1 → dropped and the original data is kept.
- Async reset: assert rst low mid-stream between clock edges with 3 outstanding → all outputs immediately take their reset values (issue_ready_out=1, rx_valid_out=0, outstanding_out=0, err_out=0).
